// File: rtl/game_pkg.sv
// Shared game definitions: projectile FSM states, screen geometry and launch-row helper.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    FLY  = 3'b010,
    COOL = 3'b100
  } proj_state_t;

  localparam int unsigned H_MAX     = 799;
  localparam int unsigned V_MAX     = 524;
  localparam int unsigned H_VIS_MIN = 144;
  localparam int unsigned H_VIS_MAX = 783;
  localparam int unsigned V_VIS_MIN = 35;
  localparam int unsigned V_VIS_MAX = 514;

  // Row a new shot appears on; clamps to vmin when the player sits too close to the top.
  function automatic logic [9:0] launch_row(input logic [9:0] pv, input logic [9:0] vmin,
                                            input logic [9:0] voff);
    logic [10:0] lim;
    lim = {1'b0, vmin} + {1'b0, voff};
    return ({1'b0, pv} >= lim) ? pv - voff : vmin;
  endfunction

endpackage

// File: rtl/projectile_ctrl_rise_detect.sv
// Registered 1-bit rising-edge detector; clear drops the history like reset does.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (reset || clear) q <= 1'b0;
    else                q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/projectile_ctrl.sv
// Single-shot projectile launcher/mover with post-retire cooldown; all outputs registered.
// Build option PROJ_AUTOFIRE_EN: a held fire button relaunches once per cooldown period.
module projectile_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SPEED    = 4,
  parameter int unsigned V_MIN    = 35,
  parameter int unsigned V_OFFSET = 20,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       fire,
  input  logic       frame_tick,
  input  logic [9:0] player_h,
  input  logic [9:0] player_v,
  input  logic       hit,
  output logic [9:0] projectile_h,
  output logic [9:0] projectile_v,
  output logic       active,
  output logic [7:0] shots
);

  localparam logic [9:0] SPEED_W    = 10'(SPEED);
  localparam logic [9:0] V_MIN_W    = 10'(V_MIN);
  localparam logic [9:0] V_OFFSET_W = 10'(V_OFFSET);
  localparam logic [9:0] STEP_LIM   = 10'(V_MIN + SPEED);
  localparam logic [7:0] COOL_W     = 8'(COOLDOWN);

  proj_state_t state;
  logic [7:0]  cnt;
  logic        fire_rise;
  logic        launch;

  rise_detect u_fire_rise (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .d     (fire),
    .rise  (fire_rise)
  );

`ifdef PROJ_AUTOFIRE_EN
  assign launch = fire | fire_rise;
`else
  assign launch = fire_rise;
`endif

  always_ff @(posedge clk) begin
    if (reset || start) begin
      state        <= IDLE;
      projectile_h <= '0;
      projectile_v <= '0;
      active       <= 1'b0;
      shots        <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state        <= FLY;
            projectile_h <= player_h;
            projectile_v <= launch_row(player_v, V_MIN_W, V_OFFSET_W);
            active       <= 1'b1;
            if (shots != 8'hFF) shots <= shots + 8'd1;
          end
        end
        FLY: begin
          // Limit is checked before the subtract so the row never wraps.
          if (hit || (frame_tick && projectile_v < STEP_LIM)) begin
            state  <= COOL;
            active <= 1'b0;
            cnt    <= COOL_W;
          end else if (frame_tick) begin
            projectile_v <= projectile_v - SPEED_W;
          end
        end
        COOL: begin
          if (frame_tick) begin
            if (cnt == 8'd0) state <= IDLE;
            else             cnt   <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_projectile_ctrl.sv
// Directed bench for projectile_ctrl: vector table plus hand sequences for cooldown, start/reset, saturation.
module tb_projectile_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, fire, frame_tick, hit;
  logic [9:0] player_h, player_v;
  logic [9:0] projectile_h, projectile_v;
  logic       active;
  logic [7:0] shots;

  int pass_cnt = 0;
  int total    = 0;

  projectile_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .fire         (fire),
    .frame_tick   (frame_tick),
    .player_h     (player_h),
    .player_v     (player_v),
    .hit          (hit),
    .projectile_h (projectile_h),
    .projectile_v (projectile_v),
    .active       (active),
    .shots        (shots)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       fi;
    logic       tk;
    logic       ht;
    logic [9:0] ph;
    logic [9:0] pv;
    logic       e_act;
    logic [9:0] e_h;
    logic [9:0] e_v;
    logic [7:0] e_shots;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic cool_out();
    repeat (9) tick();
  endtask

  task automatic launch(input logic [9:0] h, input logic [9:0] v);
    player_h = h;
    player_v = v;
    fire     = 1'b1;
    step();
    fire     = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_shots"},  32'(shots),  32'd0);
    check({tag, "_h"},      32'(projectile_h), 32'd0);
    check({tag, "_v"},      32'(projectile_v), 32'd0);
    check({tag, "_state"},  32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd320, 10'd400, 1'b0, 10'd0,   10'd0,   8'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd320, 10'd400, 1'b1, 10'd320, 10'd380, 8'd1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd320, 10'd400, 1'b1, 10'd320, 10'd376, 8'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd100, 10'd200, 1'b1, 10'd320, 10'd372, 8'd1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd320, 10'd400, 1'b1, 10'd320, 10'd372, 8'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd320, 10'd400, 1'b0, 10'd320, 10'd372, 8'd1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd320, 10'd400, 1'b0, 10'd320, 10'd372, 8'd1};

    reset = 1'b1; start = 1'b0; fire = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    player_h = 10'd0; player_v = 10'd0;
    step();
    step();
    check_cleared("reset");
    check("reset_cnt", 32'(dut.cnt), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start      = vecs[i].st;
      fire       = vecs[i].fi;
      frame_tick = vecs[i].tk;
      hit        = vecs[i].ht;
      player_h   = vecs[i].ph;
      player_v   = vecs[i].pv;
      step();
      check($sformatf("vec%0d_active", i), 32'(active),       32'(vecs[i].e_act));
      check($sformatf("vec%0d_h", i),      32'(projectile_h), 32'(vecs[i].e_h));
      check($sformatf("vec%0d_v", i),      32'(projectile_v), 32'(vecs[i].e_v));
      check($sformatf("vec%0d_shots", i),  32'(shots),        32'(vecs[i].e_shots));
    end
    start = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    check("hit_cnt_loaded", 32'(dut.cnt), 32'd8);
    check("hit_state", 32'(dut.state), 32'(COOL));

    // Fire held through the whole cooldown.
    fire = 1'b1; player_h = 10'd320; player_v = 10'd400;
    repeat (8) tick();
    check("cool8_state", 32'(dut.state), 32'(COOL));
    check("cool8_cnt", 32'(dut.cnt), 32'd0);
    check("cool8_active", 32'(active), 32'd0);
    tick();
`ifdef PROJ_AUTOFIRE_EN
    check("held_after_cool_active", 32'(active), 32'd1);
    check("held_after_cool_shots", 32'(shots), 32'd2);
`else
    check("held_after_cool_active", 32'(active), 32'd0);
    check("held_after_cool_shots", 32'(shots), 32'd1);
    check("held_after_cool_state", 32'(dut.state), 32'(IDLE));
`endif
    fire = 1'b0;
    step();
    fire = 1'b1;
    step();
    fire = 1'b0;
    check("refire_active", 32'(active), 32'd1);
    check("refire_shots", 32'(shots), 32'd2);
    check("refire_v", 32'(projectile_v), 32'd380);

    repeat (10) tick();
    check("ten_ticks_v", 32'(projectile_v), 32'd340);
    check("ten_ticks_active", 32'(active), 32'd1);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("hit_active", 32'(active), 32'd0);
    check("hit_v_held", 32'(projectile_v), 32'd340);
    cool_out();

    // Top boundary: 39 can still step to 35, 35 cannot.
    launch(10'd500, 10'd59);
    check("launch39_v", 32'(projectile_v), 32'd39);
    check("launch39_h", 32'(projectile_h), 32'd500);
    check("launch39_shots", 32'(shots), 32'd3);
    tick();
    check("step_to35_v", 32'(projectile_v), 32'd35);
    check("step_to35_active", 32'(active), 32'd1);
    tick();
    check("retire35_active", 32'(active), 32'd0);
    check("retire35_v", 32'(projectile_v), 32'd35);
    check("retire35_state", 32'(dut.state), 32'(COOL));
    cool_out();
    launch(10'd500, 10'd58);
    check("launch38_v", 32'(projectile_v), 32'd38);
    tick();
    check("retire38_active", 32'(active), 32'd0);
    check("retire38_v", 32'(projectile_v), 32'd38);
    check("retire38_state", 32'(dut.state), 32'(COOL));
    cool_out();

    launch(10'd300, 10'd270);
    check("launch250_v", 32'(projectile_v), 32'd250);
    start = 1'b1;
    step();
    start = 1'b0;
    check_cleared("start");
    launch(10'd300, 10'd270);
    check("relaunch_shots", 32'(shots), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_cleared("midreset");

    // Saturation of the shot counter.
    for (int n = 0; n < 255; n++) begin
      launch(10'd200, 10'd400);
      hit = 1'b1;
      step();
      hit = 1'b0;
      cool_out();
    end
    check("shots_255", 32'(shots), 32'd255);
    launch(10'd200, 10'd40);
    check("sat_shots", 32'(shots), 32'd255);
    check("clamp_v", 32'(projectile_v), 32'd35);
    check("clamp_active", 32'(active), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
